// File: rtl/ext_slt_gen_pkg.sv
// Shared types and constants for the expanded-slot generator.
package ext_slt_gen_pkg;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_HOLD = 1'b1
    } wr_state_e;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_WAIT = 2'd1,
        A_DONE = 2'd2
    } wait_state_e;

    localparam int          PAGE_W          = 2;
    localparam logic [15:0] SUBREG_ADDR_DEF = 16'hFFFF;

    // Sub-slot number stored for a 16 KiB page.
    function automatic logic [PAGE_W-1:0] page_sub(input logic [7:0] subreg,
                                                   input logic [1:0] page);
        return subreg[page*PAGE_W +: PAGE_W];
    endfunction

endpackage

// File: rtl/slt_wait_gen.sv
// /WAIT burst generator: one burst of WAIT_CYC clocks per sub-slot strobe.
//
// state  | meaning
// A_IDLE | no access in progress, watching for an access start
// A_WAIT | /WAIT driven low, counter running down
// A_DONE | burst finished, waiting for the strobe to end
module slt_wait_gen
    import ext_slt_gen_pkg::*;
#(
    parameter int WAIT_CYC = 0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sltsl_n_i,
    input  logic start_i,
    input  logic strobes_idle_i,
    output logic wait_drv_o
);

    wait_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    // State and counter registers, updated on the falling slot clock edge.
    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= A_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a deselected slot aborts any burst.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_drv_o = (state_q == A_WAIT);
        if (sltsl_n_i) begin
            state_d = A_IDLE;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                A_IDLE: begin
                    if (start_i) begin
                        if (WAIT_CYC > 0) begin
                            state_d = A_WAIT;
                            cnt_d   = 3'(WAIT_CYC - 1);
                        end else begin
                            state_d = A_DONE;
                        end
                    end
                end
                A_WAIT: begin
                    if (cnt_q == 3'd0) state_d = A_DONE;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                A_DONE: begin
                    if (strobes_idle_i) state_d = A_IDLE;
                end
                default: state_d = A_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ext_slt_gen.sv
// Expanded-slot generator: sub-slot register, page decode, bus drivers.
//
// state  | meaning
// W_IDLE | waiting for a write strobe to the sub-slot register
// W_HOLD | register loaded, waiting for the strobe to end
module ext_slt_gen
    import ext_slt_gen_pkg::*;
#(
    parameter int          NUM_SUB     = 4,
    parameter logic [15:0] SUBREG_ADDR = SUBREG_ADDR_DEF,
    parameter int          WAIT_CYC    = 0
) (
    input  logic               SLT_CLOCK,
    input  logic               SLT_RESETn,
    input  logic               SLT_SLTSL,
    input  logic               SLT_WEn,
    input  logic               SLT_RDn,
    input  logic [15:0]        SLT_A,
    inout  wire  [7:0]         SLT_D,
    output logic               SLT_BUSDIR,
    output wire                SLT_WAITn,
    output logic [NUM_SUB-1:0] EXTSLT
);

    wr_state_e         wr_state_q, wr_state_d;
    logic [7:0]        subreg_q, subreg_d;
    logic              addr_hit;
    logic              reg_sel;
    logic [PAGE_W-1:0] sub_n;
    logic              sub_ok;
    logic              access_start;
    logic [3:0]        sel_n;
    logic              wait_drv;

    assign addr_hit     = (SLT_A == SUBREG_ADDR);
    assign reg_sel      = addr_hit & ~SLT_SLTSL;
    assign sub_n        = page_sub(subreg_q, SLT_A[15:14]);
    assign sub_ok       = (int'(sub_n) < NUM_SUB);
    assign access_start = ~SLT_SLTSL & (~SLT_RDn | ~SLT_WEn) & ~addr_hit & sub_ok;
    assign SLT_BUSDIR   = SLT_RDn | SLT_SLTSL;

    // Register write FSM state and sub-slot register.
    always_ff @(negedge SLT_CLOCK or negedge SLT_RESETn) begin
        if (!SLT_RESETn) begin
            wr_state_q <= W_IDLE;
            subreg_q   <= 8'h00;
        end else begin
            wr_state_q <= wr_state_d;
            subreg_q   <= subreg_d;
        end
    end

    // Load once on strobe entry, then hold until the strobe ends.
    always_comb begin
        wr_state_d = wr_state_q;
        subreg_d   = subreg_q;
        case (wr_state_q)
            W_IDLE: begin
                if (reg_sel && !SLT_WEn) begin
                    subreg_d   = SLT_D;
                    wr_state_d = W_HOLD;
                end
            end
            W_HOLD: begin
                if (SLT_WEn || !reg_sel) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Active-low sub-slot select for the current page.
    always_comb begin
        sel_n = 4'hF;
        if (!SLT_SLTSL && !addr_hit && sub_ok) sel_n[sub_n] = 1'b0;
    end

    assign EXTSLT = sel_n[NUM_SUB-1:0];

    // Register reads back inverted; open-drain so only zeros are driven.
    for (genvar i = 0; i < 8; i++) begin : g_rd
        assign SLT_D[i] = (reg_sel && !SLT_RDn && subreg_q[i]) ? 1'b0 : 1'bz;
    end

    slt_wait_gen #(
        .WAIT_CYC(WAIT_CYC)
    ) u_wait (
        .clk_i         (SLT_CLOCK),
        .rst_n_i       (SLT_RESETn),
        .sltsl_n_i     (SLT_SLTSL),
        .start_i       (access_start),
        .strobes_idle_i(SLT_RDn & SLT_WEn),
        .wait_drv_o    (wait_drv)
    );

    assign SLT_WAITn = wait_drv ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ext_slt_gen.sv
// Bench for ext_slt_gen: two instances with different NUM_SUB / WAIT_CYC
// share one bus stimulus and are checked against a page/sub-slot model.
module tb_ext_slt_gen;

    localparam int N0 = 4;
    localparam int W0 = 3;
    localparam int N1 = 2;
    localparam int W1 = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sltsl, wen, rdn;
    logic [15:0] a;
    logic        d_oe;
    logic [7:0]  d_drv;
    wire  [7:0]  slt_d0, slt_d1;
    wire         waitn0, waitn1;
    logic        busdir0, busdir1;
    logic [N0-1:0] ext0;
    logic [N1-1:0] ext1;

    int passed = 0;
    int total  = 0;
    logic [7:0] subreg_m;

    always #5 clk = ~clk;

    assign slt_d0 = d_oe ? d_drv : 8'hzz;
    assign slt_d1 = d_oe ? d_drv : 8'hzz;
    pullup (waitn0);
    pullup (waitn1);
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (slt_d0[i]);
        pullup (slt_d1[i]);
    end

    ext_slt_gen #(.NUM_SUB(N0), .SUBREG_ADDR(16'hFFFF), .WAIT_CYC(W0)) dut0 (
        .SLT_CLOCK(clk), .SLT_RESETn(rst_n), .SLT_SLTSL(sltsl), .SLT_WEn(wen),
        .SLT_RDn(rdn), .SLT_A(a), .SLT_D(slt_d0), .SLT_BUSDIR(busdir0),
        .SLT_WAITn(waitn0), .EXTSLT(ext0));

    ext_slt_gen #(.NUM_SUB(N1), .SUBREG_ADDR(16'hFFFF), .WAIT_CYC(W1)) dut1 (
        .SLT_CLOCK(clk), .SLT_RESETn(rst_n), .SLT_SLTSL(sltsl), .SLT_WEn(wen),
        .SLT_RDn(rdn), .SLT_A(a), .SLT_D(slt_d1), .SLT_BUSDIR(busdir1),
        .SLT_WAITn(waitn1), .EXTSLT(ext1));

    // Expected EXTSLT: the page's 2-bit field picks one active-low line.
    function automatic int exp_ext(input logic [7:0] sr, input logic [15:0] addr,
                                   input logic sel_n, input int nsub);
        int page = int'(addr[15:14]);
        int n    = (int'(sr) >> (2 * page)) % 4;
        int v    = (1 << nsub) - 1;
        if (!sel_n && addr != 16'hFFFF && n < nsub) v = v & ~(1 << n);
        return v;
    endfunction

    // Expected /WAIT burst length for one strobe to addr.
    function automatic int exp_len(input logic [7:0] sr, input logic [15:0] addr,
                                   input int w, input int nsub);
        int n = (int'(sr) >> (2 * int'(addr[15:14]))) % 4;
        if (addr == 16'hFFFF || n >= nsub) return 0;
        return w;
    endfunction

    task automatic bus_idle();
        sltsl = 1'b1; wen = 1'b1; rdn = 1'b1; d_oe = 1'b0; a = 16'h0000;
    endtask

    task automatic write_reg(input logic [7:0] v, input int hold);
        @(posedge clk);
        a = 16'hFFFF; sltsl = 1'b0; d_drv = v; d_oe = 1'b1; wen = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            d_drv = ~v;
        end
        wen = 1'b1;
        @(posedge clk);
        bus_idle();
        subreg_m = v;
    endtask

    task automatic check_read(input string tag);
        @(posedge clk);
        a = 16'hFFFF; sltsl = 1'b0; rdn = 1'b0;
        #1;
        total++;
        if (slt_d0 !== ~subreg_m) $display("FAIL %s rd0: got %h expected %h", tag, slt_d0, ~subreg_m);
        else passed++;
        total++;
        if (slt_d1 !== ~subreg_m) $display("FAIL %s rd1: got %h expected %h", tag, slt_d1, ~subreg_m);
        else passed++;
        total++;
        if (busdir0 !== 1'b0) $display("FAIL %s busdir: got %b expected 0", tag, busdir0);
        else passed++;
        @(posedge clk);
        bus_idle();
    endtask

    task automatic check_sel(input logic [15:0] addr, input string tag);
        @(posedge clk);
        a = addr; sltsl = 1'b0;
        #1;
        total++;
        if (int'(ext0) !== exp_ext(subreg_m, addr, 1'b0, N0))
            $display("FAIL %s ext0 @%h: got %b expected %0h", tag, addr, ext0, exp_ext(subreg_m, addr, 1'b0, N0));
        else passed++;
        total++;
        if (int'(ext1) !== exp_ext(subreg_m, addr, 1'b0, N1))
            $display("FAIL %s ext1 @%h: got %b expected %0h", tag, addr, ext1, exp_ext(subreg_m, addr, 1'b0, N1));
        else passed++;
        total++;
        if (busdir1 !== 1'b1) $display("FAIL %s busdir1: got %b expected 1", tag, busdir1);
        else passed++;
        sltsl = 1'b1;
    endtask

    // One read strobe of 10 clocks; /WAIT must be low exactly for the first
    // expected-length clocks and released for the rest, then stay released.
    task automatic run_burst(input logic [15:0] addr, input string tag);
        int e0 = exp_len(subreg_m, addr, W0, N0);
        int e1 = exp_len(subreg_m, addr, W1, N1);
        int lows0 = 0, lows1 = 0, err0 = 0, err1 = 0;
        @(posedge clk);
        a = addr; sltsl = 1'b0; rdn = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            if (waitn0 === 1'b0) lows0++;
            if (waitn1 === 1'b0) lows1++;
            if ((waitn0 === 1'b0) != (k <= e0)) err0++;
            if ((waitn1 === 1'b0) != (k <= e1)) err1++;
        end
        total++;
        if (err0 != 0) $display("FAIL %s wait0 @%h: got %0d low clocks (%0d bad) expected %0d", tag, addr, lows0, err0, e0);
        else passed++;
        total++;
        if (err1 != 0) $display("FAIL %s wait1 @%h: got %0d low clocks (%0d bad) expected %0d", tag, addr, lows1, err1, e1);
        else passed++;
        rdn = 1'b1;
        @(posedge clk);
        @(posedge clk);
        total++;
        if ({waitn0, waitn1} !== 2'b11) $display("FAIL %s wait_end: got %b expected 11", tag, {waitn0, waitn1});
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus_idle(); d_drv = 8'h00; subreg_m = 8'h00;
        @(posedge clk);
        a = 16'hFFFF; sltsl = 1'b0; rdn = 1'b0;
        #1;
        total++;
        if (slt_d0 !== 8'hFF) $display("FAIL rst_d: got %h expected ff", slt_d0);
        else passed++;
        total++;
        if ({waitn0, waitn1} !== 2'b11) $display("FAIL rst_wait: got %b expected 11", {waitn0, waitn1});
        else passed++;
        rdn = 1'b1; a = 16'h4000;
        #1;
        total++;
        if ({ext0, ext1} !== 6'b1110_10) $display("FAIL rst_ext: got %b expected 111010", {ext0, ext1});
        else passed++;
        @(posedge clk);
        bus_idle(); rst_n = 1'b1;
    endtask

    task automatic test_first_access();
        check_read("first_rd");
        check_sel(16'h4000, "first_sel");
    endtask

    task automatic test_write_e4();
        write_reg(8'hE4, 5);
        check_read("e4_rd");
        for (int p = 0; p < 4; p++) check_sel(16'(p * 16'h4000), "e4_sel");
    endtask

    task automatic test_numsub();
        write_reg(8'h0C, 2);
        check_sel(16'h4000, "ns_sel");
        run_burst(16'h4000, "ns_burst");
    endtask

    task automatic test_back_to_back();
        write_reg(8'h10, 1);
        run_burst(16'h8000, "b2b_1");
        run_burst(16'h8000, "b2b_2");
        bus_idle();
    endtask

    task automatic test_sltsl_abort();
        @(posedge clk);
        a = 16'h8000; sltsl = 1'b0; rdn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        total++;
        if ({waitn0, waitn1} !== 2'b00) $display("FAIL abort_pre: got %b expected 00", {waitn0, waitn1});
        else passed++;
        sltsl = 1'b1;
        @(posedge clk);
        total++;
        if ({waitn0, waitn1} !== 2'b11) $display("FAIL abort_rel: got %b expected 11", {waitn0, waitn1});
        else passed++;
        rdn = 1'b1;
        run_burst(16'h8000, "abort_next");
        bus_idle();
    endtask

    task automatic test_reset_in_wait();
        @(posedge clk);
        a = 16'h8000; sltsl = 1'b0; rdn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({waitn0, waitn1} !== 2'b11) $display("FAIL rw_wait: got %b expected 11", {waitn0, waitn1});
        else passed++;
        subreg_m = 8'h00;
        a = 16'hFFFF;
        #1;
        total++;
        if (slt_d1 !== 8'hFF) $display("FAIL rw_d: got %h expected ff", slt_d1);
        else passed++;
        @(posedge clk);
        bus_idle(); rst_n = 1'b1;
        check_read("rw_rd");
        check_sel(16'h0000, "rw_sel");
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            logic [7:0] v = 8'($urandom_range(0, 255));
            write_reg(v, int'($urandom_range(1, 5)));
            check_read("rnd_rd");
            for (int j = 0; j < 3; j++) check_sel(16'($urandom), "rnd_sel");
            run_burst(16'($urandom), "rnd_burst");
            bus_idle();
        end
    endtask

    initial begin
        test_reset();
        test_first_access();
        test_write_e4();
        test_numsub();
        test_back_to_back();
        test_sltsl_abort();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ext_slt_gen.md
EXT_SLT_GEN -- requirements
Module: ext_slt_gen

Interface
REQ-001 Parameter NUM_SUB, default 4, legal 2..4: number of sub-slot select outputs.
REQ-002 Parameter SUBREG_ADDR, default 16'hFFFF: address of the sub-slot register.
REQ-003 Parameter WAIT_CYC, default 0, legal 0..7: /WAIT clocks inserted per sub-slot access; 0 disables /WAIT.
REQ-004 SLT_CLOCK  in  1  slot clock; the only clock; all state updates on the falling edge.
REQ-005 SLT_RESETn  in  1  asynchronous, active-low reset.
REQ-006 SLT_SLTSL  in  1  primary slot select, active low.
REQ-007 SLT_WEn, SLT_RDn  in  1 each  bus write and read strobes, active low.
REQ-008 SLT_A  in  16  bus address.
REQ-009 SLT_D  inout  8  data bus; driven open-drain, low bits only.
REQ-010 SLT_BUSDIR  out  1  equals SLT_RDn | SLT_SLTSL.
REQ-011 SLT_WAITn  out  1  open-drain /WAIT: driven 0 or released to Z.
REQ-012 EXTSLT  out  NUM_SUB  sub-slot selects, active low, push-pull.

Function
REQ-013 RegSel = (SLT_A == SUBREG_ADDR) & ~SLT_SLTSL.
REQ-014 8-bit register SubReg holds the sub-slot number per page: [1:0] page 0, [3:2] page 1, [5:4] page 2, [7:6] page 3; page = SLT_A[15:14].
REQ-015 Write FSM with states W_IDLE and W_HOLD.
REQ-016 In W_IDLE, a clock edge with RegSel & ~SLT_WEn loads SubReg from SLT_D and enters W_HOLD.
REQ-017 W_HOLD returns to W_IDLE on the first edge with SLT_WEn high or RegSel low.
REQ-018 SubReg is loaded exactly once per write strobe, however long the strobe.
REQ-019 Read: while RegSel & ~SLT_RDn, SLT_D bit i is driven 0 where ~SubReg[i] is 0; all other bits are Z; the read is combinational with no latency.
REQ-020 Selected sub-slot n = SubReg field of the current page.
REQ-021 EXTSLT[n] is 0 while ~SLT_SLTSL & (SLT_A != SUBREG_ADDR) & (n < NUM_SUB); all other EXTSLT bits are 1.
REQ-022 n >= NUM_SUB selects no sub-slot: EXTSLT is all 1 and no /WAIT is generated.
REQ-023 EXTSLT is combinational from bus inputs and SubReg, so a write takes effect from the next access.
REQ-024 Wait FSM with states A_IDLE, A_WAIT and A_DONE.
REQ-025 Access start is ~SLT_SLTSL & (~SLT_RDn | ~SLT_WEn) & (SLT_A != SUBREG_ADDR) & (n < NUM_SUB).
REQ-026 A_IDLE: on access start, with WAIT_CYC > 0, enter A_WAIT and load the counter with WAIT_CYC-1; with WAIT_CYC = 0, go to A_DONE.
REQ-027 A_WAIT: SLT_WAITn is driven 0; the counter decrements each edge; the edge at which the counter is 0 moves to A_DONE.
REQ-028 SLT_WAITn is held low for exactly WAIT_CYC clocks after the edge that detected the start.
REQ-029 A_DONE: SLT_WAITn is Z; return to A_IDLE when SLT_RDn & SLT_WEn, or when SLT_SLTSL is high; one /WAIT burst per strobe.
REQ-030 In any state, SLT_SLTSL going high forces A_IDLE on the next edge and releases SLT_WAITn in the same edge.
REQ-031 Register accesses never assert SLT_WAITn.

Reset
REQ-032 While SLT_RESETn is low, asynchronously: SubReg = 8'h00, write FSM = W_IDLE, wait FSM = A_IDLE, counter = 0.
REQ-033 While SLT_RESETn is low, SLT_WAITn = Z and SLT_D = Z.
REQ-034 EXTSLT follows REQ-021 with SubReg = 0 during and after reset.
REQ-035 Reset asserted during A_WAIT releases SLT_WAITn immediately.

Structure
REQ-036 A shared package holds the FSM state encodings, the page field width (2) and the default SUBREG_ADDR.
REQ-037 One sub-module, slt_wait_gen, contains the wait FSM and counter; the register, decode and bus drivers stay in the top level.

Verification
REQ-038 Reset, then read FFFFh with SLTSL low -> SLT_D reads FFh; EXTSLT[0] is low for an access to 4000h.
REQ-039 Write E4h to FFFFh with WEn held low for 5 clocks -> SubReg = E4h, loaded once; read FFFFh -> 1Bh; access to 0000h/4000h/8000h/C000h -> EXTSLT low on bit 0/1/2/3.
REQ-040 With NUM_SUB=2, write 0Ch and access 4000h -> EXTSLT = 2'b11 and SLT_WAITn stays Z.
REQ-041 With WAIT_CYC=3, read 8000h with sub-slot 1 -> SLT_WAITn low for exactly 3 clocks, then Z until RDn rises; a back-to-back second read produces a second 3-clock burst.
REQ-042 With WAIT_CYC=5, SLTSL deasserted after 2 wait clocks -> SLT_WAITn is Z at the next edge and the FSM is in A_IDLE.
REQ-043 SLT_RESETn pulsed low in A_WAIT -> SLT_WAITn is Z immediately, SubReg = 00h, and the next access to 0000h selects EXTSLT[0].
